commit_trace_tx: RTL and testbench

Transmit side of the pipeline commit trace. Captures every instruction retired at the WB stage into a record FIFO. Serialises each record as a 4-beat, 32-bit packet on a valid/ready stream. The packet stream goes to a trace sink, such as the bench scoreboard or a UART bridge. The block sits beside the WB stage of the 5-stage core and has no effect on pipeline timing.

---
 rtl/commit_trace_tx.sv | 232 +++++++++++++++++++++++
 tb/tb_commit_trace_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_tx.sv
// -----------------------------------------------------------------------------
// commit_trace_tx
//
// Transmit side of the pipeline commit trace. Every instruction retired at WB
// (while enable is high) becomes a four-word record in a small FIFO. Records
// leave as 4-beat packets on a valid/ready stream:
//   beat 0 header : {MARKER, seq[15:0], rd|0, regWrite, memWrite, pend_drop}
//   beat 1        : pc
//   beat 2        : instruction word
//   beat 3        : writeback data (0 when the instruction does not write rd)
// The block only observes WB and never stalls the core. When the FIFO is full,
// records are dropped. Dropped records still consume a sequence number, and
// the next stored header has its drop flag set.
//
// Ports
//   clk, reset         core clock, asynchronous active-low reset
//   enable             capture enable
//   wb_*_in            retiring-instruction fields from the WB stage
//   tx_valid/ready     stream handshake
//   tx_data, tx_last   beat payload, last-beat marker
//   fifo_count         records held, including the record being transmitted
//   drop_count         saturating count of dropped records
//   overflow           sticky drop indicator
//
// FSM states
//   state | meaning
//   IDLE  | FIFO empty, no beat offered
//   HDR   | offering header of the record at the FIFO head
//   PC    | offering pc
//   INS   | offering instruction word
//   DAT   | offering writeback data (tx_last); record pops on handshake
// -----------------------------------------------------------------------------
module commit_trace_tx #(
  parameter int          DEPTH  = 8,
  parameter logic [7:0]  MARKER = 8'hC0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     wb_isValid_in,
  input  logic [31:0]              wb_pc_in,
  input  logic [31:0]              wb_instr_in,
  input  logic [4:0]               wb_rd_in,
  input  logic                     wb_regWrite_in,
  input  logic                     wb_memWrite_in,
  input  logic [31:0]              wb_data_in,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [31:0]              tx_data,
  output logic                     tx_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              drop_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PC   = 3'd2,
    S_INS  = 3'd3,
    S_DAT  = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic [15:0]     seq_q;
  logic            pend_drop_q;
  logic [15:0]     drop_count_q;
  logic            overflow_q;

  logic [31:0]     hdr_mem [DEPTH];
  logic [31:0]     pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];
  logic [31:0]     dat_mem [DEPTH];

  logic            commit;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic [31:0]     hdr_in;

  // ---------------------------------------------------------------------------
  // Capture decisions
  // ---------------------------------------------------------------------------
  assign commit = enable && wb_isValid_in;
  assign full   = (count_q == CW'(DEPTH));
  // A record leaves only when its last beat handshakes.
  assign pop    = (state_q == S_DAT) && tx_ready;
  // A slot freed by a pop on this same edge can take the new record, so a
  // full FIFO that is completing a packet still accepts the commit.
  assign push   = commit && (!full || pop);
  assign drop   = commit && !push;

  assign hdr_in = {MARKER,
                   seq_q,
                   (wb_regWrite_in ? wb_rd_in : 5'd0),
                   wb_regWrite_in,
                   wb_memWrite_in,
                   pend_drop_q};

  // ---------------------------------------------------------------------------
  // Record storage (data path only, no reset needed)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      hdr_mem[wr_ptr_q] <= hdr_in;
      pc_mem[wr_ptr_q]  <= wb_pc_in;
      ins_mem[wr_ptr_q] <= wb_instr_in;
      dat_mem[wr_ptr_q] <= wb_regWrite_in ? wb_data_in : 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequence number and drop bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_q        <= '0;
      pend_drop_q  <= 1'b0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      // Every commit consumes a number, so drops appear as seq gaps.
      if (commit) seq_q <= seq_q + 16'd1;
      if (drop) begin
        pend_drop_q <= 1'b1;
        overflow_q  <= 1'b1;
        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
      end else if (push) begin
        pend_drop_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Packet FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Packet FSM: next state
  // A push on the current edge is considered so that a record committed at
  // edge N is offered right after edge N, and so that packets run
  // back-to-back when the next record arrives with the last beat.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (count_q != '0 || push) state_d = S_HDR;
      S_HDR:  if (tx_ready) state_d = S_PC;
      S_PC:   if (tx_ready) state_d = S_INS;
      S_INS:  if (tx_ready) state_d = S_DAT;
      S_DAT: begin
        if (tx_ready) begin
          if (count_q > CW'(1) || push) state_d = S_HDR;
          else                           state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packet FSM: outputs
  // Beats are read straight from the storage flops at the FIFO head, which
  // stay put until the record pops, so the payload is stable under stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 32'd0;
    case (state_q)
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_mem[rd_ptr_q];
      end
      S_PC: begin
        tx_valid = 1'b1;
        tx_data  = pc_mem[rd_ptr_q];
      end
      S_INS: begin
        tx_valid = 1'b1;
        tx_data  = ins_mem[rd_ptr_q];
      end
      S_DAT: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = dat_mem[rd_ptr_q];
      end
      default: begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = 32'd0;
      end
    endcase
  end

  assign fifo_count = count_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
module tb_commit_trace_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        wb_isValid_in = 1'b0;
  logic [31:0] wb_pc_in = '0;
  logic [31:0] wb_instr_in = '0;
  logic [4:0]  wb_rd_in = '0;
  logic        wb_regWrite_in = 1'b0;
  logic        wb_memWrite_in = 1'b0;
  logic [31:0] wb_data_in = '0;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic        tx_last;
  logic [2:0]  fifo_count;
  logic [15:0] drop_count;
  logic        overflow;

  commit_trace_tx #(.DEPTH(4), .MARKER(8'hC0)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .wb_isValid_in  (wb_isValid_in),
    .wb_pc_in       (wb_pc_in),
    .wb_instr_in    (wb_instr_in),
    .wb_rd_in       (wb_rd_in),
    .wb_regWrite_in (wb_regWrite_in),
    .wb_memWrite_in (wb_memWrite_in),
    .wb_data_in     (wb_data_in),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data),
    .tx_last        (tx_last),
    .fifo_count     (fifo_count),
    .drop_count     (drop_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [32:0] exp_q[$];
  logic [15:0] exp_seq = '0;
  logic        exp_pend = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  bit          bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_hdr(input logic [15:0] seq, input logic [4:0] rd,
                                         input logic rw, input logic mw, input logic pend);
    return {8'hC0, seq, (rw ? rd : 5'd0), rw, mw, pend};
  endfunction

  // Called just after a rising edge; the commit lands on the next edge.
  task automatic commit(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                        input logic rw, input logic mw, input logic [31:0] data, input bit stored);
    if (stored) begin
      exp_q.push_back({1'b0, mk_hdr(exp_seq, rd, rw, mw, exp_pend)});
      exp_q.push_back({1'b0, pc});
      exp_q.push_back({1'b0, instr});
      exp_q.push_back({1'b1, (rw ? data : 32'd0)});
      exp_pend = 1'b0;
    end else begin
      exp_pend = 1'b1;
    end
    exp_seq = exp_seq + 16'd1;
    wb_isValid_in  = 1'b1;
    wb_pc_in       = pc;
    wb_instr_in    = instr;
    wb_rd_in       = rd;
    wb_regWrite_in = rw;
    wb_memWrite_in = mw;
    wb_data_in     = data;
    @(posedge clk);
    #1;
    wb_isValid_in  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_seq  = '0;
    exp_pend = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d beats still outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every handshaken beat against the scoreboard and
  // checks that a stalled beat is held.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, tx_valid}, 32'd1);
        check("hold_data", tx_data, prev_data);
        check("hold_last", {31'd0, tx_last}, {31'd0, prev_last});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h expected no beat", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", tx_data, e[31:0]);
          check("beat_last", {31'd0, tx_last}, {31'd0, e[32]});
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", tx_data, 32'd0);
    check("rst_last", {31'd0, tx_last}, 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset    = 1'b1;
    enable   = 1'b1;
    tx_ready = 1'b1;

    // Single commit: header offered in the cycle right after the commit edge.
    commit(32'h100, 32'h0050_0093, 5'd1, 1'b1, 1'b0, 32'd5, 1'b1);
    check("hdr_latency_valid", {31'd0, tx_valid}, 32'd1);
    check("hdr_first", tx_data, 32'hC000_000C);
    wait_drain("drain_single");
    check("idle_valid", {31'd0, tx_valid}, 32'd0);
    check("idle_count", 32'(fifo_count), 32'd0);

    // enable low: no capture, seq holds.
    enable = 1'b0;
    wb_isValid_in = 1'b1;
    @(posedge clk);
    #1;
    wb_isValid_in = 1'b0;
    enable = 1'b1;
    check("disabled_count", 32'(fifo_count), 32'd0);
    check("disabled_valid", {31'd0, tx_valid}, 32'd0);

    // Store: rd masked, data beat zero, seq 1 -> header C0000102.
    commit(32'h104, 32'h0011_2023, 5'd7, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check("store_hdr", tx_data, 32'hC000_0102);
    wait_drain("drain_store");

    // Backpressure over three queued records.
    do_reset();
    tx_ready = 1'b0;
    commit(32'h200, 32'h0000_0013, 5'd2, 1'b1, 1'b0, 32'h11, 1'b1);
    commit(32'h204, 32'h0000_0113, 5'd3, 1'b1, 1'b0, 32'h22, 1'b1);
    commit(32'h208, 32'h0000_0213, 5'd4, 1'b1, 1'b0, 32'h33, 1'b1);
    check("bp_count3", 32'(fifo_count), 32'd3);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      tx_ready = bp_pat[i % 4];
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
    wait_drain("drain_bp");
    check("bp_count0", 32'(fifo_count), 32'd0);

    // Overflow: 6 commits into 4 slots, seq 4 and 5 dropped.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      commit(32'h300 + 32'(i * 4), 32'h0000_1000 + 32'(i), 5'd5, 1'b1, 1'b0, 32'(i), (i < 4));
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_drops", 32'(drop_count), 32'd2);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    tx_ready = 1'b1;
    wait_drain("drain_ovf");
    commit(32'h400, 32'h0000_2000, 5'd6, 1'b1, 1'b0, 32'h66, 1'b1);
    check("ovf_gap_hdr", tx_data, 32'hC000_0635);
    wait_drain("drain_ovf_tail");
    check("ovf_drops_after", 32'(drop_count), 32'd2);
    check("ovf_flag_sticky", {31'd0, overflow}, 32'd1);

    // Full FIFO with commit on the beat-3 handshake edge.
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      commit(32'h500 + 32'(i * 4), 32'h0000_3000 + 32'(i), 5'd8, 1'b1, 1'b0, 32'(i + 16), 1'b1);
    check("fp_full", 32'(fifo_count), 32'd4);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("fp_in_dat", {31'd0, tx_last}, 32'd1);
    commit(32'h600, 32'h0000_4000, 5'd9, 1'b1, 1'b0, 32'h99, 1'b1);
    check("fp_count_same", 32'(fifo_count), 32'd4);
    check("fp_no_drop", 32'(drop_count), 32'd0);
    wait_drain("drain_fp");
    check("fp_no_ovf", {31'd0, overflow}, 32'd0);

    // Reset during the PC beat.
    do_reset();
    tx_ready = 1'b1;
    commit(32'h700, 32'h0000_5000, 5'd10, 1'b1, 1'b0, 32'h77, 1'b1);
    @(posedge clk);
    #1;
    check("mid_pc_beat", tx_data, 32'h700);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_data", tx_data, 32'd0);
    check("mid_rst_last", {31'd0, tx_last}, 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    exp_q.delete();
    exp_seq  = '0;
    exp_pend = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    commit(32'h800, 32'h0000_6000, 5'd11, 1'b1, 1'b0, 32'h88, 1'b1);
    check("post_rst_hdr", tx_data, 32'hC000_005C);
    wait_drain("drain_post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
